game_menu_ctrl: RTL and testbench



---
 rtl/game_menu_ctrl.sv | 131 +++++++++++++
 tb/tb_game_menu_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/game_menu_ctrl.sv
// Board-size menu and game start/return controller.
// Buttons step the size with lockout and auto-repeat; a click starts a game.
module game_menu_ctrl #(
  parameter int SIZE_W          = 3,
  parameter int SIZE_MIN        = 2,
  parameter int SIZE_MAX        = 4,
  parameter int SIZE_DEFAULT    = 2,
  parameter int DEBOUNCE_CYCLES = 100000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int WRAP            = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              top,
  input  logic              bottom,
  input  logic              mouse_left,
  input  logic              game_over,
  output logic [SIZE_W-1:0] board_size,
  output logic              is_game_on,
  output logic              game_start
);

  localparam int CMAX = (DEBOUNCE_CYCLES > REPEAT_DELAY + 1)
                      ? DEBOUNCE_CYCLES : REPEAT_DELAY + 1;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(REPEAT_RATE + 1);

  localparam logic [CW-1:0]   DEB  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   DLY  = CW'(REPEAT_DELAY);
  localparam logic [RW-1:0]   RATE = RW'(REPEAT_RATE);
  localparam logic [SIZE_W:0] SMIN = (SIZE_W+1)'(SIZE_MIN);
  localparam logic [SIZE_W:0] SMAX = (SIZE_W+1)'(SIZE_MAX);

  typedef enum logic [1:0] {
    MENU     = 2'd0,
    GAME     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t state, state_nx;

  // bit 0 = top, bit 1 = bottom, bit 2 = mouse_left
  logic [2:0] s1, s2, pv, ed;
  logic [CW-1:0] lockout, hold;
  logic [RW-1:0] rcnt;
  logic one_btn, held, edge_ok, rpt_hit, do_step;
  logic [SIZE_W:0] sz_ext, sz_nx;

  assign ed      = s2 & ~pv;
  assign one_btn = s2[0] ^ s2[1];
  assign held    = one_btn & ((s2[0] & pv[0]) | (s2[1] & pv[1]));
  assign edge_ok = one_btn & (ed[0] | ed[1]) & (lockout == '0);

  always_comb begin
    rpt_hit = 1'b0;
    if (REPEAT_DELAY != 0 && held) begin
      if (hold != DLY) rpt_hit = (hold + CW'(1)) == DLY;
      else             rpt_hit = (rcnt + RW'(1)) == RATE;
    end
  end

  // a click in the same cycle wins over any size step
  assign do_step = (edge_ok | rpt_hit) & (state == MENU) & ~ed[2];

  always_comb begin
    sz_ext = {1'b0, board_size};
    sz_nx  = sz_ext;
    unique case (1'b1)
      s2[1]: begin
        if (sz_ext >= SMAX) sz_nx = (WRAP != 0) ? SMIN : sz_ext;
        else                sz_nx = sz_ext + 1'b1;
      end
      default: begin
        if (sz_ext <= SMIN) sz_nx = (WRAP != 0) ? SMAX : sz_ext;
        else                sz_nx = sz_ext - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= MENU;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MENU:     if (ed[2])     state_nx = GAME;
      GAME:     if (game_over) state_nx = WAIT_REL;
      WAIT_REL: if (!s2[2])    state_nx = MENU;
      default:                 state_nx = MENU;
    endcase
  end

  always_comb begin
    is_game_on = (state == GAME);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1         <= '0;
      s2         <= '0;
      pv         <= '0;
      lockout    <= '0;
      hold       <= '0;
      rcnt       <= '0;
      board_size <= SIZE_W'(SIZE_DEFAULT);
      game_start <= 1'b0;
    end else begin
      s1 <= {mouse_left, bottom, top};
      s2 <= s1;
      pv <= s2;
      if (edge_ok)              lockout <= DEB;
      else if (lockout != '0)   lockout <= lockout - CW'(1);
      if (!held || REPEAT_DELAY == 0) begin
        hold <= '0;
        rcnt <= '0;
      end else if (hold != DLY) begin
        hold <= hold + CW'(1);
      end else if (rcnt + RW'(1) == RATE) begin
        rcnt <= '0;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      if (do_step) board_size <= sz_nx[SIZE_W-1:0];
      game_start <= (state == MENU) & ed[2];
    end
  end

endmodule

// File: tb/tb_game_menu_ctrl.sv
// Bench for game_menu_ctrl: saturating and wrapping instances driven in step.
module tb_game_menu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic top = 1'b0;
  logic bottom = 1'b0;
  logic mouse_left = 1'b0;
  logic game_over = 1'b0;
  logic [2:0] sz0, sz1;
  logic on0, on1, st0, st1;

  always #5 clk = ~clk;

  game_menu_ctrl #(
    .SIZE_W(3), .SIZE_MIN(2), .SIZE_MAX(4), .SIZE_DEFAULT(2),
    .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(0)
  ) dut0 (
    .clk(clk), .rst(rst), .top(top), .bottom(bottom),
    .mouse_left(mouse_left), .game_over(game_over),
    .board_size(sz0), .is_game_on(on0), .game_start(st0)
  );

  game_menu_ctrl #(
    .SIZE_W(3), .SIZE_MIN(2), .SIZE_MAX(4), .SIZE_DEFAULT(2),
    .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_RATE(5), .WRAP(1)
  ) dut1 (
    .clk(clk), .rst(rst), .top(top), .bottom(bottom),
    .mouse_left(mouse_left), .game_over(game_over),
    .board_size(sz1), .is_game_on(on1), .game_start(st1)
  );

  typedef struct {
    logic       rn, t, b, m, go;
    int         n;
    logic [2:0] s0, s1;
    logic       on, st;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int nvec = 0;
  int nmis = 0;

  function automatic vec_t mk(int rn, int t, int b, int m, int go,
                              int n, int s0, int s1, int on, int st);
    vec_t v;
    v.rn = (rn != 0); v.t = (t != 0); v.b = (b != 0);
    v.m  = (m != 0);  v.go = (go != 0);
    v.n  = n;
    v.s0 = 3'(s0); v.s1 = 3'(s1);
    v.on = (on != 0); v.st = (st != 0);
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL vec%0d %s: got %0d, expected %0d", idx, nm, act, exp);
    end
  endtask

  // hold the inputs for v.n edges, then check the state after the last edge
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    exp_q.push_back(v);
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      rst = v.rn; top = v.t; bottom = v.b;
      mouse_left = v.m; game_over = v.go;
      @(posedge clk);
    end
    #1;
    e = exp_q.pop_front();
    cmp("size_sat",  idx, {1'b0, sz0}, {1'b0, e.s0});
    cmp("size_wrap", idx, {1'b0, sz1}, {1'b0, e.s1});
    cmp("on_sat",    idx, {3'b0, on0}, {3'b0, e.on});
    cmp("on_wrap",   idx, {3'b0, on1}, {3'b0, e.on});
    cmp("start_sat", idx, {3'b0, st0}, {3'b0, e.st});
    cmp("start_wrap",idx, {3'b0, st1}, {3'b0, e.st});
  endtask

  initial begin
    int idx;
    // reset and release
    tbl.push_back(mk(0,0,0,0,0, 3, 2,2,0,0));
    tbl.push_back(mk(1,0,0,0,0, 2, 2,2,0,0));
    // single edge: update two edges after first sample
    tbl.push_back(mk(1,0,1,0,0, 1, 2,2,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 2,2,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 3,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 3,3,0,0));
    // edge inside lockout is dropped
    tbl.push_back(mk(1,0,1,0,0, 1, 3,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 3, 3,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 6, 3,3,0,0));
    tbl.push_back(mk(1,0,1,0,0, 1, 3,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 3,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 4,4,0,0));
    // step past max: saturate vs wrap
    tbl.push_back(mk(1,0,0,0,0,10, 4,4,0,0));
    tbl.push_back(mk(1,0,1,0,0, 1, 4,4,0,0));
    tbl.push_back(mk(1,0,0,0,0, 3, 4,2,0,0));
    // three spaced top presses
    tbl.push_back(mk(1,0,0,0,0,10, 4,2,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1, 4,2,0,0));
    tbl.push_back(mk(1,0,0,0,0, 3, 3,4,0,0));
    tbl.push_back(mk(1,0,0,0,0,10, 3,4,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1, 3,4,0,0));
    tbl.push_back(mk(1,0,0,0,0, 3, 2,3,0,0));
    tbl.push_back(mk(1,0,0,0,0,10, 2,3,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1, 2,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 3, 2,2,0,0));
    // auto-repeat on a held bottom
    tbl.push_back(mk(1,0,0,0,0,10, 2,2,0,0));
    tbl.push_back(mk(1,0,1,0,0, 2, 2,2,0,0));
    tbl.push_back(mk(1,0,1,0,0, 1, 3,3,0,0));
    tbl.push_back(mk(1,0,1,0,0,19, 3,3,0,0));
    tbl.push_back(mk(1,0,1,0,0, 1, 4,4,0,0));
    tbl.push_back(mk(1,0,1,0,0, 4, 4,4,0,0));
    tbl.push_back(mk(1,0,1,0,0, 1, 4,2,0,0));
    tbl.push_back(mk(1,0,1,0,0, 4, 4,2,0,0));
    tbl.push_back(mk(1,0,1,0,0, 1, 4,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 5, 4,3,0,0));
    // both buttons together
    tbl.push_back(mk(1,0,0,0,0,10, 4,3,0,0));
    tbl.push_back(mk(1,1,1,0,0,30, 4,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 5, 4,3,0,0));
    // click starts a game, one-cycle pulse
    tbl.push_back(mk(1,0,0,1,0, 1, 4,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 4,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 4,3,1,1));
    tbl.push_back(mk(1,0,0,0,0, 1, 4,3,1,0));
    // buttons frozen in game
    tbl.push_back(mk(1,0,0,0,0, 2, 4,3,1,0));
    tbl.push_back(mk(1,0,1,0,0, 1, 4,3,1,0));
    tbl.push_back(mk(1,0,0,0,0,25, 4,3,1,0));
    // game_over with mouse held, then wait for release
    tbl.push_back(mk(1,0,0,1,0, 3, 4,3,1,0));
    tbl.push_back(mk(1,0,0,1,1, 1, 4,3,0,0));
    tbl.push_back(mk(1,0,0,1,0, 5, 4,3,0,0));
    tbl.push_back(mk(1,1,0,1,0, 1, 4,3,0,0));
    tbl.push_back(mk(1,0,0,1,0, 5, 4,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 5, 4,3,0,0));
    // restart
    tbl.push_back(mk(1,0,0,1,0, 1, 4,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 4,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1, 4,3,1,1));
    tbl.push_back(mk(1,0,0,0,0, 1, 4,3,1,0));

    idx = 0;
    foreach (tbl[i]) begin
      apply(tbl[i], idx);
      idx++;
    end

    // reset in the middle of a game
    apply(mk(0,0,0,0,0, 1, 2,2,0,0), idx++);
    apply(mk(1,0,0,0,0, 3, 2,2,0,0), idx++);

    // click and bottom edge in the same cycle
    apply(mk(1,0,1,1,0, 1, 2,2,0,0), idx++);
    apply(mk(1,0,0,0,0, 1, 2,2,0,0), idx++);
    apply(mk(1,0,0,0,0, 1, 2,2,1,1), idx++);
    apply(mk(1,0,0,0,0, 1, 2,2,1,0), idx++);
    apply(mk(1,0,0,0,0, 5, 2,2,1,0), idx++);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
